// File: rtl/microcode_sequencer.sv
// Microcode sequencer: decodes (opcode, micro-step) into a 16-bit control word plus advance/halt.
// Define SEQ_COND_JUMP_EN to add the carry/zero flag registers and the JC/JZ conditional jumps.
module microcode_sequencer #(
  parameter int INSTRUCTION_STEPS = 8,
  localparam int STEP_WIDTH = $clog2(INSTRUCTION_STEPS)
) (
  input  logic                  mclk,
  input  logic                  mrst_n,
  input  logic                  mclk_en,
  input  logic [STEP_WIDTH-1:0] i_step,
  input  logic [3:0]            i_opcode,
  input  logic                  i_alu_carry,
  input  logic                  i_alu_zero,
  output logic [15:0]           o_ctrl,
  output logic                  o_adv,
  output logic                  o_halt,
  output logic                  o_illegal
);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;

`ifdef SEQ_COND_JUMP_EN
  localparam logic [15:0] C_FI  = 16'h0001;
`else
  localparam logic [15:0] C_FI  = 16'h0000;
`endif

  localparam int BIT_HLT = 15;
  localparam int BIT_FI  = 0;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [7:0]  w_step;
  logic [15:0] w_ctrl;
  logic        w_adv;
  logic        w_illegal_op;
  logic        w_carry;
  logic        w_zero;
  logic        r_halt;
  logic        r_illegal;

  assign w_step = 8'(i_step);

`ifdef SEQ_COND_JUMP_EN
  logic r_carry;
  logic r_zero;

  // Flags only capture on flag-in steps, so a halt on the same step never blocks the update.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (mclk_en && w_ctrl[BIT_FI]) begin
      r_carry <= i_alu_carry;
      r_zero  <= i_alu_zero;
    end
  end

  assign w_carry = r_carry;
  assign w_zero  = r_zero;
`else
  logic w_unused_alu_flags;

  assign w_carry = 1'b0;
  assign w_zero  = 1'b0;
  assign w_unused_alu_flags = i_alu_carry ^ i_alu_zero;
`endif

  always_comb begin
    case (i_opcode)
      4'h9, 4'hA, 4'hB, 4'hC, 4'hD: w_illegal_op = 1'b1;
`ifndef SEQ_COND_JUMP_EN
      OP_JC, OP_JZ:                 w_illegal_op = 1'b1;
`endif
      default:                      w_illegal_op = 1'b0;
    endcase
  end

  // Anything not matched below is past the opcode's last step: emit nothing and advance.
  always_comb begin
    w_ctrl = 16'h0000;
    w_adv  = 1'b1;
    if (w_step == 8'd0) begin
      w_ctrl = C_CO | C_MI;
      w_adv  = 1'b0;
    end else if (w_step == 8'd1) begin
      w_ctrl = C_RO | C_II | C_CE;
      w_adv  = 1'b0;
    end else begin
      case (i_opcode)
        OP_LDA: begin
          case (w_step)
            8'd2: begin w_ctrl = C_IO | C_MI; w_adv = 1'b0; end
            8'd3: w_ctrl = C_RO | C_AI;
            default: ;
          endcase
        end
        OP_ADD, OP_SUB: begin
          case (w_step)
            8'd2: begin w_ctrl = C_IO | C_MI; w_adv = 1'b0; end
            8'd3: begin
              w_ctrl = C_RO | C_BI | ((i_opcode == OP_SUB) ? C_SU : 16'h0000);
              w_adv  = 1'b0;
            end
            8'd4: w_ctrl = C_EO | C_AI | C_FI | ((i_opcode == OP_SUB) ? C_SU : 16'h0000);
            default: ;
          endcase
        end
        OP_STA: begin
          case (w_step)
            8'd2: begin w_ctrl = C_IO | C_MI; w_adv = 1'b0; end
            8'd3: w_ctrl = C_AO | C_RI;
            default: ;
          endcase
        end
        OP_LDI: if (w_step == 8'd2) w_ctrl = C_IO | C_AI;
        OP_JMP: if (w_step == 8'd2) w_ctrl = C_IO | C_J;
`ifdef SEQ_COND_JUMP_EN
        OP_JC:  if (w_step == 8'd2 && w_carry) w_ctrl = C_IO | C_J;
        OP_JZ:  if (w_step == 8'd2 && w_zero) w_ctrl = C_IO | C_J;
`endif
        OP_OUT: if (w_step == 8'd2) w_ctrl = C_AO | C_OI;
        OP_HLT: begin
          if (w_step == 8'd2) begin
            w_ctrl = C_HLT;
            w_adv  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Halt and illegal are sticky until reset; both latch only on enabled edges.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      r_halt    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (mclk_en) begin
      if (w_ctrl[BIT_HLT]) r_halt <= 1'b1;
      if (w_step == 8'd2 && w_illegal_op) r_illegal <= 1'b1;
    end
  end

  assign o_ctrl    = w_ctrl;
  assign o_adv     = w_adv;
  assign o_halt    = r_halt | w_ctrl[BIT_HLT];
  assign o_illegal = r_illegal;

endmodule
